golden_nonce_reporter: RTL and testbench
========================================

# golden_nonce_reporter

Buffers golden nonces produced by the hashing core and presents them one at a time to the host-communication side for readout. It receives the core's one-cycle `new_nonce` pulse plus its `golden_nonce` value, corrects the value by a fixed pipeline offset, and holds it in a small FIFO. It presents the FIFO head on a registered read port with an explicit pop strobe. It sits in the hash clock domain between the control unit and the JTAG/host comm block, and replaces the single-register nonce handoff so bursts of hits are not lost.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `NONCE_OFFSET`, 32'd0, subtracted (mod 2^32) from every stored nonce on output.
- `EMPTY_WORD`, 32'hFFFFFFFF, value on `tx_nonce` when the FIFO is empty.
- `rx_hash_clk`  in  1  sole clock, rising edge.
- `rx_reset_n`  in  1  reset, asynchronous assert, active-low.
- `rx_new_nonce`  in  1  high for one cycle per hit; every high cycle is one push request.
- `rx_golden_nonce`  in  32  nonce value, valid when `rx_new_nonce` is high.
- `rx_read`  in  1  host pop strobe; one cycle = one pop.
- `rx_clear_overflow`  in  1  zeroes `tx_overflow_count`.
- `tx_nonce`  out  32  head entry minus `NONCE_OFFSET`, or `EMPTY_WORD`; registered.
- `tx_nonce_valid`  out  1  FIFO non-empty; registered.
- `tx_count`  out  $clog2(DEPTH+1)  current occupancy; registered.
- `tx_overflow_count`  out  8  hits dropped because the FIFO was full; saturates at 255.

## Operation
- Reset values:
  - `tx_nonce` = `EMPTY_WORD`.
  - `tx_nonce_valid` = 0.
  - `tx_count` = 0.
  - `tx_overflow_count` = 0.
  - FIFO pointers = 0.
  - Duplicate filter invalid.
- Duplicate filter:
  - `last_nonce`/`last_valid` record the most recently accepted raw `rx_golden_nonce`.
  - A push whose value equals `last_nonce` while `last_valid` = 1 is discarded silently. It is not counted as overflow.
  - Only reset clears `last_valid`. Popping does not clear it.
- Push accepted if `rx_new_nonce` = 1, the value is not a duplicate, and either count < DEPTH or a pop is accepted in the same cycle.
- Push when full with no pop: the value is dropped and `tx_overflow_count` increments, saturating at 255. A dropped value does not update `last_nonce`.
- Pop accepted if `rx_read` = 1 and count > 0. `rx_read` on an empty FIFO is ignored and has no side effect.
- Simultaneous push and pop:
  - Non-empty FIFO: count is unchanged, head advances, the new value goes to the tail.
  - Empty FIFO: the pop is ignored and the push is accepted.
- Output state machine:
  - EMPTY: `tx_nonce_valid` = 0, `tx_nonce` = `EMPTY_WORD`.
  - PRESENT: `tx_nonce_valid` = 1, `tx_nonce` = head − `NONCE_OFFSET`.
  - EMPTY→PRESENT on an accepted push.
  - PRESENT→EMPTY on a pop that leaves count = 0 with no same-cycle push.
- `rx_clear_overflow` coinciding with an overflow drop: the clear wins, and the result is 0.
- Arithmetic:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Count is one bit wider.
  - Offset subtraction is 32-bit modulo with no flag.

## Timing
- All outputs are registered and reflect FIFO state after the capturing edge.
- Push at edge N: `tx_nonce_valid`/`tx_nonce`/`tx_count` update at edge N (visible in cycle N+1). Push-to-visible latency is 1 cycle.
- Pop at edge N: the next head (or `EMPTY_WORD`) is visible in cycle N+1.
- The host must not pop again until it has sampled the new `tx_nonce`. Back-to-back pops every cycle are legal and drain one entry per cycle.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously), and FIFO contents are discarded. Release is synchronized externally.

## Structure
- Package `golden_nonce_pkg`: `NONCE_W` = 32, `OVF_W` = 8, default `EMPTY_WORD`, and the output-state enum {`ST_EMPTY`, `ST_PRESENT`}.
- Sub-module `nonce_fifo`: a synchronous DEPTH×32 FIFO with push/pop/full/empty/count and a show-ahead head output. The top adds the duplicate filter, overflow counter, offset subtraction and output registers.

## Test plan
- Reset, then single push of 32'h0000_1234 with `NONCE_OFFSET` = 2 → next cycle `tx_nonce_valid` = 1, `tx_nonce` = 32'h0000_1232, `tx_count` = 1. `rx_read` → `tx_nonce` = 32'hFFFFFFFF, `valid` = 0.
- Push 5 distinct values (1..5) on consecutive cycles with DEPTH = 4 and no reads → `tx_count` = 4, `tx_overflow_count` = 1. Draining yields 1,2,3,4 in order.
- Push 32'hA, then 32'hA again, then 32'hB → `tx_count` = 2, `overflow` = 0. Reads return A then B. A later push of B after draining is also filtered.
- Full FIFO plus same-cycle push of 9 and `rx_read` → `tx_count` stays 4, `overflow` = 0. The last entry read is 9.
- 300 drops while full → `tx_overflow_count` = 255. `rx_clear_overflow` in the same cycle as a drop → 0.
- `rx_read` when empty → all outputs unchanged. Async `rx_reset_n` low with count = 3 mid-cycle → outputs go to reset values before the next clock edge.

Source files
------------

// File: rtl/golden_nonce_pkg.sv
// rtl/golden_nonce_pkg.sv - shared widths, defaults and output-state encoding for the golden nonce reporter
//
// Purpose : common definitions imported by nonce_fifo and golden_nonce_reporter.
// Contents: NONCE_W    - nonce word width
//           OVF_W      - overflow counter width
//           DEFAULT_EMPTY_WORD - word presented while nothing is buffered
//           out_state_t - read-port presentation state

package golden_nonce_pkg;

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned OVF_W   = 8;

    localparam logic [NONCE_W-1:0] DEFAULT_EMPTY_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - synchronous DEPTH x NONCE_W show-ahead FIFO
//
// Purpose : storage for accepted golden nonces. push/pop are already qualified
//           by the caller (push never on full without a same-cycle pop, pop
//           never on empty), so this block does no guarding of its own.
// Ports   : hash_clk   - clock, rising edge
//           rst_n      - asynchronous active-low reset of pointers and count
//           push       - write push_data at the tail this cycle
//           push_data  - value to write
//           pop        - advance the head this cycle
//           full/empty - occupancy flags (from registered count)
//           count      - registered occupancy, one bit wider than the pointers
//           head       - current head entry (show-ahead)
//           head_next  - head entry as it will be after this edge

module nonce_fifo
    import golden_nonce_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         hash_clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [NONCE_W-1:0]           push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [NONCE_W-1:0]           head,
    output logic [NONCE_W-1:0]           head_next
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [NONCE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_inc;

    assign rd_ptr_inc = rd_ptr + PTR_ONE;
    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr];

    // Predict the head after this edge so the caller can register it and
    // present it with single-cycle latency. A push lands at the head only
    // when the FIFO is, or is about to become, empty.
    always_comb begin
        head_next = head;
        if (empty) begin
            head_next = push_data;
        end else if (pop) begin
            if (count == CNT_ONE) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_inc];
            end
        end
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Contents need no reset: the pointers define what is valid.
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/golden_nonce_reporter.sv
// rtl/golden_nonce_reporter.sv - buffers golden nonces from the hashing core for host readout
//
// Purpose : filters repeated hits, buffers accepted nonces in nonce_fifo,
//           counts hits lost to a full buffer and presents the head entry
//           (minus NONCE_OFFSET) on a registered read port with a pop strobe.
// Ports   : rx_hash_clk       - clock, rising edge
//           rx_reset_n        - asynchronous active-low reset
//           rx_new_nonce      - one push request per high cycle
//           rx_golden_nonce   - nonce value accompanying rx_new_nonce
//           rx_read           - host pop strobe
//           rx_clear_overflow - zero the overflow counter
//           tx_nonce          - head minus NONCE_OFFSET, or EMPTY_WORD
//           tx_nonce_valid    - buffer non-empty
//           tx_count          - buffer occupancy
//           tx_overflow_count - saturating count of hits dropped while full

module golden_nonce_reporter
    import golden_nonce_pkg::*;
#(
    parameter int unsigned        DEPTH        = 4,
    parameter logic [NONCE_W-1:0] NONCE_OFFSET = 32'd0,
    parameter logic [NONCE_W-1:0] EMPTY_WORD   = DEFAULT_EMPTY_WORD
) (
    input  logic                         rx_hash_clk,
    input  logic                         rx_reset_n,
    input  logic                         rx_new_nonce,
    input  logic [NONCE_W-1:0]           rx_golden_nonce,
    input  logic                         rx_read,
    input  logic                         rx_clear_overflow,
    output logic [NONCE_W-1:0]           tx_nonce,
    output logic                         tx_nonce_valid,
    output logic [$clog2(DEPTH+1)-1:0]   tx_count,
    output logic [OVF_W-1:0]             tx_overflow_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OVF_W-1:0] OVF_MAX = '1;
    localparam logic [OVF_W-1:0] OVF_ONE = OVF_W'(1);

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [NONCE_W-1:0] fifo_head;
    logic [NONCE_W-1:0] fifo_head_next;

    logic [NONCE_W-1:0] last_nonce;
    logic               last_valid;

    logic               is_dup;
    logic               pop_acc;
    logic               push_acc;
    logic               drop;

    out_state_t         state;
    out_state_t         state_next;
    logic [NONCE_W-1:0] nonce_next;

    // A repeat of the last accepted value is discarded before it can reach
    // the full/overflow decision, so duplicates never count as drops.
    assign is_dup   = last_valid && (rx_golden_nonce == last_nonce);
    assign pop_acc  = rx_read && !fifo_empty;
    assign push_acc = rx_new_nonce && !is_dup && (!fifo_full || pop_acc);
    assign drop     = rx_new_nonce && !is_dup && fifo_full && !pop_acc;

    nonce_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .hash_clk  (rx_hash_clk),
        .rst_n     (rx_reset_n),
        .push      (push_acc),
        .push_data (rx_golden_nonce),
        .pop       (pop_acc),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head),
        .head_next (fifo_head_next)
    );

    assign tx_count = fifo_count;

    always_ff @(posedge rx_hash_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            last_nonce <= '0;
            last_valid <= 1'b0;
        end else if (push_acc) begin
            last_nonce <= rx_golden_nonce;
            last_valid <= 1'b1;
        end
    end

    // Clear takes priority over a coincident drop.
    always_ff @(posedge rx_hash_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            tx_overflow_count <= '0;
        end else if (rx_clear_overflow) begin
            tx_overflow_count <= '0;
        end else if (drop && (tx_overflow_count != OVF_MAX)) begin
            tx_overflow_count <= tx_overflow_count + OVF_ONE;
        end
    end

    always_ff @(posedge rx_hash_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        nonce_next = EMPTY_WORD;
        case (state)
            ST_EMPTY: begin
                if (push_acc) begin
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (pop_acc && !push_acc && (fifo_count == CNT_ONE)) begin
                    state_next = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (state_next == ST_PRESENT) begin
            nonce_next = fifo_head_next - NONCE_OFFSET;
        end
    end

    assign tx_nonce_valid = (state == ST_PRESENT);

    always_ff @(posedge rx_hash_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            tx_nonce <= EMPTY_WORD;
        end else begin
            tx_nonce <= nonce_next;
        end
    end

    // fifo_head is the show-ahead view; only head_next feeds the register.
    logic unused_head;
    assign unused_head = ^fifo_head;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// tb/tb_golden_nonce_reporter.sv - self-checking bench for golden_nonce_reporter

module tb_golden_nonce_reporter;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] OFFSET = 32'd2;
    localparam logic [31:0] EMPTYW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_nonce = 1'b0;
    logic [31:0] golden = '0;
    logic        rd = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] tx_nonce;
    logic        tx_valid;
    logic [2:0]  tx_count;
    logic [7:0]  tx_ovf;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] m_last;
    bit          m_last_valid;
    int          m_ovf;

    golden_nonce_reporter #(
        .DEPTH        (DEPTH),
        .NONCE_OFFSET (OFFSET),
        .EMPTY_WORD   (EMPTYW)
    ) dut (
        .rx_hash_clk       (clk),
        .rx_reset_n        (rst_n),
        .rx_new_nonce      (new_nonce),
        .rx_golden_nonce   (golden),
        .rx_read           (rd),
        .rx_clear_overflow (clr),
        .tx_nonce          (tx_nonce),
        .tx_nonce_valid    (tx_valid),
        .tx_count          (tx_count),
        .tx_overflow_count (tx_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last_valid = 0;
        m_last = '0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit n, input logic [31:0] v, input bit r, input bit c);
        bit pop, dup, acc, drp;
        pop = r && (q.size() > 0);
        dup = n && m_last_valid && (v == m_last);
        acc = 0;
        drp = 0;
        if (n && !dup) begin
            if (q.size() < DEPTH || pop) acc = 1;
            else drp = 1;
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(v);
            m_last = v;
            m_last_valid = 1;
        end
        if (c) m_ovf = 0;
        else if (drp && m_ovf < 255) m_ovf++;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_nonce;
        exp_nonce = (q.size() > 0) ? (q[0] - OFFSET) : EMPTYW;
        chk({tag, ".nonce"}, tx_nonce, exp_nonce);
        chk({tag, ".valid"}, {31'd0, tx_valid}, {31'd0, q.size() > 0});
        chk({tag, ".count"}, {29'd0, tx_count}, 32'(q.size()));
        chk({tag, ".ovf"},   {24'd0, tx_ovf},   32'(m_ovf));
    endtask

    // One clock: drive after the falling edge, model at the rising edge,
    // sample at the next falling edge.
    task automatic cyc(input bit n, input logic [31:0] v, input bit r, input bit c,
                       input string tag, input bit do_chk);
        new_nonce = n;
        golden = v;
        rd = r;
        clr = c;
        @(posedge clk);
        model_step(n, v, r, c);
        @(negedge clk);
        new_nonce = 0;
        rd = 0;
        clr = 0;
        if (do_chk) check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && q.size() > 0; i++) cyc(0, 0, 1, 0, tag, 1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset.nonce_const", tx_nonce, 32'hFFFF_FFFF);
        rst_n = 1;
        @(negedge clk);

        // Single push with offset 2
        cyc(1, 32'h0000_1234, 0, 0, "single_push", 1);
        chk("single_push.value", tx_nonce, 32'h0000_1232);
        chk("single_push.cnt", {29'd0, tx_count}, 32'd1);
        cyc(0, 0, 1, 0, "single_pop", 1);
        chk("single_pop.empty", tx_nonce, 32'hFFFF_FFFF);

        // Five pushes into depth 4
        for (int i = 1; i <= 5; i++) cyc(1, 32'(i), 0, 0, "burst", 1);
        chk("burst.cnt", {29'd0, tx_count}, 32'd4);
        chk("burst.ovf", {24'd0, tx_ovf}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("burst.order", tx_nonce, 32'(i) - OFFSET);
            cyc(0, 0, 1, 0, "burst_drain", 1);
        end
        cyc(0, 0, 0, 1, "clr", 1);

        // Duplicate filter
        cyc(1, 32'hA, 0, 0, "dup", 1);
        cyc(1, 32'hA, 0, 0, "dup", 1);
        cyc(1, 32'hB, 0, 0, "dup", 1);
        chk("dup.cnt", {29'd0, tx_count}, 32'd2);
        chk("dup.ovf", {24'd0, tx_ovf}, 32'd0);
        chk("dup.headA", tx_nonce, 32'hA - OFFSET);
        cyc(0, 0, 1, 0, "dup_rd", 1);
        chk("dup.headB", tx_nonce, 32'hB - OFFSET);
        cyc(0, 0, 1, 0, "dup_rd", 1);
        cyc(1, 32'hB, 0, 0, "dup_after_drain", 1);
        chk("dup.filtered", {29'd0, tx_count}, 32'd0);

        // Full plus simultaneous push/pop
        for (int i = 0; i < 4; i++) cyc(1, 32'h20 + 32'(i), 0, 0, "fill", 1);
        cyc(1, 32'd9, 1, 0, "pushpop_full", 1);
        chk("pushpop.cnt", {29'd0, tx_count}, 32'd4);
        chk("pushpop.ovf", {24'd0, tx_ovf}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "pp_drain", 1);
        chk("pushpop.last", tx_nonce, 32'd9 - OFFSET);
        cyc(0, 0, 1, 0, "pp_drain", 1);

        // Saturation and clear-wins
        for (int i = 0; i < 4; i++) cyc(1, 32'h40 + 32'(i), 0, 0, "fill2", 1);
        for (int i = 0; i < 300; i++) cyc(1, 32'd1000 + 32'(i), 0, 0, "sat", (i % 50) == 0);
        check_all("sat_end");
        chk("sat.255", {24'd0, tx_ovf}, 32'd255);
        cyc(1, 32'd5000, 0, 1, "clr_drop", 1);
        chk("clr_drop.zero", {24'd0, tx_ovf}, 32'd0);
        drain("drain2");

        // Read on empty leaves everything unchanged
        cyc(0, 0, 1, 0, "rd_empty", 1);
        cyc(0, 0, 1, 0, "rd_empty", 1);

        // Async reset mid-cycle with three entries
        for (int i = 0; i < 3; i++) cyc(1, 32'h60 + 32'(i), 0, 0, "pre_rst", 1);
        chk("pre_rst.cnt", {29'd0, tx_count}, 32'd3);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_all("post_rst");

        // Randomized traffic; small value range exercises the duplicate filter
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 3) != 0, 32'($urandom_range(0, 7)) + 32'h100,
                ($urandom % 3) == 0, ($urandom % 25) == 0, "rand", 1);
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
